// File: rtl/wb_stage_fifo_if.sv
// rtl/wb_stage_fifo_if.sv - MEM-to-WB handshake and entry bus
interface wb_stage_fifo_if #(
    parameter int BUS_W = 199
) ();
    logic             ms_to_ws_valid;
    logic             ws_allowin;
    logic [BUS_W-1:0] ms_to_ws_bus;

    modport master (output ms_to_ws_valid, output ms_to_ws_bus, input ws_allowin);
    modport slave  (input ms_to_ws_valid, input ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage_fifo.sv
// rtl/wb_stage_fifo.sv - buffered writeback stage with CSR access, flush and retire counting
module wb_stage_fifo #(
    parameter int DATA_W     = 32,
    parameter int RF_AW      = 5,
    parameter int CSR_NUM_W  = 14,
    parameter int ECODE_W    = 6,
    parameter int ESUB_W     = 9,
    parameter int DEPTH      = 2,
    parameter int CSR_RD_LAT = 0,
    parameter int CNT_W      = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    wb_stage_fifo_if.slave            ms_if,
    output logic [RF_AW+DATA_W:0]     ws_to_rf_bus_o,
    output logic                      csr_re_o,
    output logic [CSR_NUM_W-1:0]      csr_num_o,
    output logic                      csr_we_o,
    output logic [DATA_W-1:0]         csr_wmask_o,
    output logic [DATA_W-1:0]         csr_wvalue_o,
    input  logic [DATA_W-1:0]         csr_rvalue_i,
    output logic                      wb_ex_o,
    output logic                      wb_ertn_flush_o,
    output logic [ECODE_W-1:0]        wb_ecode_o,
    output logic [ESUB_W-1:0]         wb_esubcode_o,
    output logic [DATA_W-1:0]         wb_pc_o,
    output logic [DATA_W-1:0]         wb_vaddr_o,
    input  logic [7:0]                ext_int_i,
    input  logic                      ipi_req_i,
    output logic [7:0]                hw_int_in_o,
    output logic                      ipi_int_in_o,
    output logic [CNT_W-1:0]          retire_cnt_o,
    output logic [DATA_W-1:0]         debug_wb_pc_o,
    output logic [3:0]                debug_wb_rf_wen_o,
    output logic [RF_AW-1:0]          debug_wb_rf_wnum_o,
    output logic [DATA_W-1:0]         debug_wb_rf_wdata_o
);
    // Entry field positions, LSB upward: pc, result, dest, gr_we, wvalue, wmask,
    // csr_we, csr_num, csr_op, vaddr, esubcode, ecode, ex, ertn.
    localparam int PC_LSB    = 0;
    localparam int RES_LSB   = PC_LSB + DATA_W;
    localparam int DEST_LSB  = RES_LSB + DATA_W;
    localparam int GRWE_BIT  = DEST_LSB + RF_AW;
    localparam int WVAL_LSB  = GRWE_BIT + 1;
    localparam int WMASK_LSB = WVAL_LSB + DATA_W;
    localparam int CSRWE_BIT = WMASK_LSB + DATA_W;
    localparam int CNUM_LSB  = CSRWE_BIT + 1;
    localparam int CSROP_BIT = CNUM_LSB + CSR_NUM_W;
    localparam int VADDR_LSB = CSROP_BIT + 1;
    localparam int ESUB_LSB  = VADDR_LSB + DATA_W;
    localparam int ECODE_LSB = ESUB_LSB + ESUB_W;
    localparam int EX_BIT    = ECODE_LSB + ECODE_W;
    localparam int ERTN_BIT  = EX_BIT + 1;
    localparam int BUS_W     = ERTN_BIT + 1;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW        = $clog2(DEPTH + 1);

    logic [BUS_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             head_wait_q, head_wait_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [8:0]       int_s1_q, int_s2_q;

    logic [BUS_W-1:0] head;
    logic             head_valid, retire, flush, push, allowin, rf_we;
    logic             h_ertn, h_ex, h_csr_op, h_csr_we, h_gr_we;
    logic [DATA_W-1:0] rf_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head       = mem_q[head_q];
    assign h_ertn     = head[ERTN_BIT];
    assign h_ex       = head[EX_BIT];
    assign h_csr_op   = head[CSROP_BIT];
    assign h_csr_we   = head[CSRWE_BIT];
    assign h_gr_we    = head[GRWE_BIT];
    assign head_valid = (count_q != '0);

    // A CSR-reading head waits one cycle for read data when the CSR file is registered.
    assign retire  = head_valid & (~h_csr_op | (CSR_RD_LAT == 0) | head_wait_q);
    assign flush   = retire & (h_ex | h_ertn);
    assign allowin = (count_q < CW'(DEPTH));
    assign push    = ms_if.ms_to_ws_valid & allowin & ~flush;

    assign rf_we    = retire & h_gr_we & ~h_ex;
    assign rf_wdata = h_csr_op ? csr_rvalue_i : head[RES_LSB +: DATA_W];

    assign ms_if.ws_allowin    = allowin;
    assign ws_to_rf_bus_o      = {rf_we, head[DEST_LSB +: RF_AW], rf_wdata};
    assign csr_re_o            = head_valid & h_csr_op;
    assign csr_num_o           = head[CNUM_LSB +: CSR_NUM_W];
    assign csr_we_o            = retire & h_csr_we & ~h_ex & ~h_ertn;
    assign csr_wmask_o         = head[WMASK_LSB +: DATA_W];
    assign csr_wvalue_o        = head[WVAL_LSB +: DATA_W];
    assign wb_ex_o             = retire & h_ex;
    assign wb_ertn_flush_o     = retire & h_ertn & ~h_ex;
    assign wb_ecode_o          = head[ECODE_LSB +: ECODE_W];
    assign wb_esubcode_o       = head[ESUB_LSB +: ESUB_W];
    assign wb_pc_o             = head[PC_LSB +: DATA_W];
    assign wb_vaddr_o          = head[VADDR_LSB +: DATA_W];
    assign hw_int_in_o         = int_s2_q[7:0];
    assign ipi_int_in_o        = int_s2_q[8];
    assign retire_cnt_o        = retire_cnt_q;
    assign debug_wb_pc_o       = head[PC_LSB +: DATA_W];
    assign debug_wb_rf_wen_o   = {4{rf_we}};
    assign debug_wb_rf_wnum_o  = head[DEST_LSB +: RF_AW];
    assign debug_wb_rf_wdata_o = rf_wdata;

    // Next-state for pointers, occupancy, CSR wait flag and retire counter; a flush empties the buffer.
    always_comb begin
        head_d       = retire ? ptr_inc(head_q) : head_q;
        tail_d       = push ? ptr_inc(tail_q) : tail_q;
        count_d      = count_q + CW'(push) - CW'(retire);
        head_wait_d  = ~retire & head_valid & h_csr_op;
        retire_cnt_d = (retire & ~h_ex) ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Buffer storage and control state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            head_wait_q  <= 1'b0;
            retire_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            head_wait_q  <= head_wait_d;
            retire_cnt_q <= retire_cnt_d;
            if (push) mem_q[tail_q] <= ms_if.ms_to_ws_bus;
        end
    end

    // Two-flop synchronisers for the asynchronous interrupt lines.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            int_s1_q <= '0;
            int_s2_q <= '0;
        end else begin
            int_s1_q <= {ipi_req_i, ext_int_i};
            int_s2_q <= int_s1_q;
        end
    end
endmodule

// File: tb/tb_wb_stage_fifo.sv
// tb/tb_wb_stage_fifo.sv - directed and randomized checks of wb_stage_fifo against a queue model
module tb_wb_stage_fifo;
    localparam int BUS_W = 199;
    localparam int DEPTH = 2;

    typedef struct packed {
        bit        ertn;
        bit        ex;
        bit [5:0]  ecode;
        bit [8:0]  esub;
        bit [31:0] vaddr;
        bit        csr_op;
        bit [13:0] csr_num;
        bit        csr_we;
        bit [31:0] wmask;
        bit [31:0] wvalue;
        bit        gr_we;
        bit [4:0]  dest;
        bit [31:0] result;
        bit [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    wb_stage_fifo_if #(.BUS_W(BUS_W)) ms_if ();

    logic [37:0] ws_to_rf_bus;
    logic        csr_re, csr_we, wb_ex, wb_ertn_flush, ipi_req, ipi_int_in;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, wb_pc, wb_vaddr;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [7:0]  ext_int, hw_int_in;
    logic [63:0] retire_cnt;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    wb_stage_fifo #(.DEPTH(DEPTH), .CSR_RD_LAT(1)) dut (
        .clk(clk), .resetn(resetn), .ms_if(ms_if),
        .ws_to_rf_bus_o(ws_to_rf_bus), .csr_re_o(csr_re), .csr_num_o(csr_num),
        .csr_we_o(csr_we), .csr_wmask_o(csr_wmask), .csr_wvalue_o(csr_wvalue),
        .csr_rvalue_i(csr_rvalue), .wb_ex_o(wb_ex), .wb_ertn_flush_o(wb_ertn_flush),
        .wb_ecode_o(wb_ecode), .wb_esubcode_o(wb_esubcode), .wb_pc_o(wb_pc),
        .wb_vaddr_o(wb_vaddr), .ext_int_i(ext_int), .ipi_req_i(ipi_req),
        .hw_int_in_o(hw_int_in), .ipi_int_in_o(ipi_int_in), .retire_cnt_o(retire_cnt),
        .debug_wb_pc_o(debug_wb_pc), .debug_wb_rf_wen_o(debug_wb_rf_wen),
        .debug_wb_rf_wnum_o(debug_wb_rf_wnum), .debug_wb_rf_wdata_o(debug_wb_rf_wdata)
    );

    ent_t            mq[$];
    bit              m_wait;
    longint unsigned m_cnt;
    bit [8:0]        s1, s2;
    int              checks = 0;
    int              failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t plain(input bit [4:0] d, input bit [31:0] r);
        ent_t e;
        e = '0;
        e.gr_we  = 1'b1;
        e.dest   = d;
        e.result = r;
        e.pc     = 32'h1c00_0000 + 32'(d) * 32'h4;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.ertn    = ($urandom_range(0, 9) == 0);
        e.ex      = ($urandom_range(0, 9) == 0);
        e.ecode   = 6'($urandom);
        e.esub    = 9'($urandom);
        e.vaddr   = $urandom;
        e.csr_op  = ($urandom_range(0, 2) == 0);
        e.csr_num = 14'($urandom);
        e.csr_we  = 1'($urandom);
        e.wmask   = $urandom;
        e.wvalue  = $urandom;
        e.gr_we   = 1'($urandom);
        e.dest    = 5'($urandom);
        e.result  = $urandom;
        e.pc      = $urandom;
        return e;
    endfunction

    // One cycle: drive inputs, check outputs against the model, then advance the model past the edge.
    task automatic step(input bit v, input ent_t e, input bit [31:0] rv, input bit [7:0] ei, input bit ip);
        ent_t h;
        bit   hv, ret, fl, rfwe, push_ok;
        @(negedge clk);
        resetn = 1'b1;
        ms_if.ms_to_ws_valid = v;
        ms_if.ms_to_ws_bus   = e;
        csr_rvalue = rv;
        ext_int    = ei;
        ipi_req    = ip;
        #1;
        hv   = (mq.size() != 0);
        h    = hv ? mq[0] : ent_t'(0);
        ret  = hv && (!h.csr_op || m_wait);
        rfwe = ret && h.gr_we && !h.ex;
        chk("allowin", 64'(ms_if.ws_allowin), 64'(mq.size() < DEPTH));
        chk("csr_re", 64'(csr_re), 64'(hv && h.csr_op));
        chk("csr_we", 64'(csr_we), 64'(ret && h.csr_we && !h.ex && !h.ertn));
        chk("wb_ex", 64'(wb_ex), 64'(ret && h.ex));
        chk("wb_ertn", 64'(wb_ertn_flush), 64'(ret && h.ertn && !h.ex));
        chk("rf_we", 64'(ws_to_rf_bus[37]), 64'(rfwe));
        chk("dbg_wen", 64'(debug_wb_rf_wen), 64'({4{rfwe}}));
        chk("retire_cnt", retire_cnt, 64'(m_cnt));
        chk("hw_int", 64'(hw_int_in), 64'(s2[7:0]));
        chk("ipi_int", 64'(ipi_int_in), 64'(s2[8]));
        if (rfwe) begin
            chk("rf_waddr", 64'(ws_to_rf_bus[36:32]), 64'(h.dest));
            chk("rf_wdata", 64'(ws_to_rf_bus[31:0]), 64'(h.csr_op ? rv : h.result));
            chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
            chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(h.csr_op ? rv : h.result));
        end
        if (hv) begin
            chk("wb_pc", 64'(wb_pc), 64'(h.pc));
            chk("dbg_pc", 64'(debug_wb_pc), 64'(h.pc));
            if (h.csr_op) chk("csr_num", 64'(csr_num), 64'(h.csr_num));
        end
        if (ret && h.csr_we && !h.ex && !h.ertn) begin
            chk("csr_wmask", 64'(csr_wmask), 64'(h.wmask));
            chk("csr_wvalue", 64'(csr_wvalue), 64'(h.wvalue));
        end
        if (ret && h.ex) begin
            chk("wb_ecode", 64'(wb_ecode), 64'(h.ecode));
            chk("wb_esub", 64'(wb_esubcode), 64'(h.esub));
            chk("wb_vaddr", 64'(wb_vaddr), 64'(h.vaddr));
        end
        fl      = ret && (h.ex || h.ertn);
        push_ok = v && (mq.size() < DEPTH) && !fl;
        if (ret) begin
            void'(mq.pop_front());
            if (!h.ex) m_cnt++;
            m_wait = 1'b0;
        end else if (hv && h.csr_op) begin
            m_wait = 1'b1;
        end
        if (fl) mq.delete();
        else if (push_ok) mq.push_back(e);
        s2 = s1;
        s1 = {ip, ei};
    endtask

    task automatic idle();
        step(1'b0, ent_t'(0), 32'h0, 8'h0, 1'b0);
    endtask

    task automatic rst(input int n);
        @(negedge clk);
        resetn = 1'b0;
        ms_if.ms_to_ws_valid = 1'b0;
        repeat (n) @(posedge clk);
        mq.delete();
        m_wait = 1'b0;
        m_cnt  = 0;
        s1     = '0;
        s2     = '0;
    endtask

    initial begin
        ent_t a, x, e, r;
        ms_if.ms_to_ws_valid = 1'b0;
        ms_if.ms_to_ws_bus   = '0;
        csr_rvalue = '0;
        ext_int    = '0;
        ipi_req    = 1'b0;

        rst(2);
        idle();
        chk("rst_cnt", retire_cnt, 64'd0);
        chk("rst_allowin", 64'(ms_if.ws_allowin), 64'd1);
        chk("rst_wen", 64'(debug_wb_rf_wen), 64'd0);

        a = plain(5'd5, 32'h11);
        step(1'b1, a, 32'h0, 8'h0, 1'b0);
        idle();
        chk("A_rfwe", 64'(ws_to_rf_bus[37]), 64'd1);
        chk("A_waddr", 64'(ws_to_rf_bus[36:32]), 64'd5);
        chk("A_wdata", 64'(ws_to_rf_bus[31:0]), 64'h11);
        idle();
        chk("A_cnt", retire_cnt, 64'd1);

        x = plain(5'd7, 32'h0);
        x.csr_op  = 1'b1;
        x.csr_num = 14'h5;
        step(1'b1, x, 32'h0, 8'h0, 1'b0);
        step(1'b1, plain(5'd8, 32'h22), 32'h1234, 8'h0, 1'b0);
        chk("X_re1", 64'(csr_re), 64'd1);
        chk("X_hold", 64'(ws_to_rf_bus[37]), 64'd0);
        step(1'b1, plain(5'd9, 32'h33), 32'hABCD, 8'h0, 1'b0);
        chk("full_allowin", 64'(ms_if.ws_allowin), 64'd0);
        chk("X_re2", 64'(csr_re), 64'd1);
        chk("X_num", 64'(csr_num), 64'h5);
        chk("X_wdata", 64'(ws_to_rf_bus[31:0]), 64'hABCD);
        idle();
        chk("Y_waddr", 64'(ws_to_rf_bus[36:32]), 64'd8);
        idle();
        chk("Z_dropped", 64'(ws_to_rf_bus[37]), 64'd0);

        e = plain(5'd10, 32'h44);
        e.ex = 1'b1; e.ecode = 6'h8; e.csr_op = 1'b1; e.vaddr = 32'hdead_0000;
        step(1'b1, e, 32'h0, 8'h0, 1'b0);
        step(1'b1, plain(5'd11, 32'h55), 32'h0, 8'h0, 1'b0);
        step(1'b1, plain(5'd12, 32'h66), 32'h0, 8'h0, 1'b0);
        chk("ex_pulse", 64'(wb_ex), 64'd1);
        chk("ex_rfwe", 64'(ws_to_rf_bus[37]), 64'd0);
        chk("ex_ecode", 64'(wb_ecode), 64'h8);
        idle();
        chk("ex_once", 64'(wb_ex), 64'd0);
        chk("ex_empty", 64'(ms_if.ws_allowin), 64'd1);
        chk("ex_cnt", retire_cnt, 64'd3);

        e = plain(5'd13, 32'h77);
        e.ex = 1'b1; e.ecode = 6'h3;
        step(1'b1, e, 32'h0, 8'h0, 1'b0);
        step(1'b1, plain(5'd14, 32'h88), 32'h0, 8'h0, 1'b0);
        chk("ex2_pulse", 64'(wb_ex), 64'd1);
        idle();
        chk("ex2_drop", 64'(ws_to_rf_bus[37]), 64'd0);

        r = plain(5'd0, 32'h0);
        r.gr_we = 1'b0; r.ertn = 1'b1; r.csr_op = 1'b1;
        step(1'b1, r, 32'h0, 8'h0, 1'b0);
        step(1'b1, plain(5'd15, 32'h99), 32'h0, 8'h0, 1'b0);
        step(1'b0, ent_t'(0), 32'h0, 8'h0, 1'b0);
        chk("ertn_pulse", 64'(wb_ertn_flush), 64'd1);
        chk("ertn_noex", 64'(wb_ex), 64'd0);
        idle();
        chk("ertn_once", 64'(wb_ertn_flush), 64'd0);
        chk("ertn_cnt", retire_cnt, 64'd4);
        chk("ertn_flushed", 64'(ws_to_rf_bus[37]), 64'd0);

        step(1'b0, ent_t'(0), 32'h0, 8'h81, 1'b1);
        step(1'b0, ent_t'(0), 32'h0, 8'h81, 1'b1);
        chk("int_t1", 64'(hw_int_in), 64'h0);
        step(1'b0, ent_t'(0), 32'h0, 8'h81, 1'b1);
        chk("int_t2", 64'(hw_int_in), 64'h81);
        chk("ipi_t2", 64'(ipi_int_in), 64'd1);

        step(1'b1, x, 32'h0, 8'h0, 1'b0);
        step(1'b1, plain(5'd16, 32'haa), 32'h0, 8'h0, 1'b0);
        rst(1);
        idle();
        chk("rst2_allowin", 64'(ms_if.ws_allowin), 64'd1);
        chk("rst2_cnt", retire_cnt, 64'd0);
        chk("rst2_int", 64'(hw_int_in), 64'h0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_ent(), $urandom, 8'($urandom), 1'($urandom));
            if (i == 300) rst(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
